// File: rtl/generador_selector_s_pkg.sv
// rtl/generador_selector_s_pkg.sv - shared debounce state encoding and S width default
package generador_selector_s_pkg;

  // Debounce FSM states; the encoding is visible on estado_dbg LEDs
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    CONFIRMA = 2'd1,
    PULSADO  = 2'd2,
    SUELTA   = 2'd3
  } estadoDeb_t;

  localparam int ANCHO_S_DEF = 2;

endpackage

// File: rtl/generador_selector_s_antirrebote.sv
// rtl/generador_selector_s_antirrebote.sv - push-button synchroniser and debounce FSM
module antirrebote
  import generador_selector_s_pkg::*;
#(
  parameter int DEB_CICLOS = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_in,
  output logic       paso,
  output logic [1:0] estado
);

  localparam int CNT_W = (DEB_CICLOS > 2) ? $clog2(DEB_CICLOS) : 1;
  // The edge that leaves a confirming state brings the count to DEB_CICLOS-1
  localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'((DEB_CICLOS > 1) ? DEB_CICLOS - 2 : 0);

  logic             btnMeta;
  logic             btnS;
  estadoDeb_t       estadoQ;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser for the raw, bouncing button
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btnMeta <= 1'b0;
      btnS    <= 1'b0;
    end else begin
      btnMeta <= btn_in;
      btnS    <= btnMeta;
    end
  end

  // Debounce FSM: a level is accepted after DEB_CICLOS stable cycles; paso fires once per press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estadoQ <= REPOSO;
      cnt     <= '0;
      paso    <= 1'b0;
    end else begin
      paso <= 1'b0;
      case (estadoQ)
        REPOSO: begin
          if (btnS) begin
            estadoQ <= CONFIRMA;
            cnt     <= '0;
          end
        end
        CONFIRMA: begin
          if (!btnS) begin
            estadoQ <= REPOSO;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_FIN) begin
              estadoQ <= PULSADO;
              paso    <= 1'b1;
            end
          end
        end
        PULSADO: begin
          if (!btnS) begin
            estadoQ <= SUELTA;
            cnt     <= '0;
          end
        end
        SUELTA: begin
          // A bounce during release goes back to PULSADO without a second step
          if (btnS) begin
            estadoQ <= PULSADO;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_FIN) begin
              estadoQ <= REPOSO;
            end
          end
        end
        default: estadoQ <= REPOSO;
      endcase
    end
  end

  assign estado = estadoQ;

endmodule

// File: rtl/generador_selector_s.sv
// rtl/generador_selector_s.sv - 2-bit S code generator driven by a debounced button or auto-run
module generador_selector_s
  import generador_selector_s_pkg::*;
#(
  parameter int DEB_CICLOS   = 1_000_000,
  parameter int PERIODO_AUTO = 50_000_000,
  parameter int ANCHO_S      = ANCHO_S_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_paso,
  input  logic               sw_auto,
  input  logic               clr,
  output logic [ANCHO_S-1:0] S,
  output logic               s_cambio,
  output logic [1:0]         estado_dbg
);

  localparam int PRE_W = (PERIODO_AUTO > 2) ? $clog2(PERIODO_AUTO) : 1;
  localparam logic [PRE_W-1:0] PRE_FIN = PRE_W'((PERIODO_AUTO > 1) ? PERIODO_AUTO - 1 : 0);

  logic               paso;
  logic               swMeta;
  logic               swS;
  logic [PRE_W-1:0]   pre;
  logic               tickAuto;
  logic [ANCHO_S-1:0] sNext;

  antirrebote #(
    .DEB_CICLOS(DEB_CICLOS)
  ) uAntirrebote (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_in(btn_paso),
    .paso  (paso),
    .estado(estado_dbg)
  );

  // Two-flop synchroniser for the raw mode switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swMeta <= 1'b0;
      swS    <= 1'b0;
    end else begin
      swMeta <= sw_auto;
      swS    <= swMeta;
    end
  end

  // Next S: clr wins, then the auto tick in auto mode or a debounced step in manual mode
  always_comb begin
    tickAuto = swS && (pre == PRE_FIN);
    sNext    = S;
    if (clr) begin
      sNext = '0;
    end else if (swS) begin
      if (tickAuto) sNext = S + ANCHO_S'(1);
    end else if (paso) begin
      sNext = S + ANCHO_S'(1);
    end
  end

  // Prescaler held at 0 outside auto mode so each entry into auto mode starts a full period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (clr || !swS || tickAuto) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // S register; s_cambio is registered alongside it so both show the new code in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S        <= '0;
      s_cambio <= 1'b0;
    end else begin
      S        <= sNext;
      s_cambio <= (sNext != S);
    end
  end

endmodule
